// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared defaults, entry type and FSM states for the branch resolve queue
package bp_pkg;

   localparam int DEF_DEPTH  = 4;
   localparam int DEF_ADDR_W = 3;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] addr;
      logic                  pred;
   } bp_entry_t;

   typedef enum logic {
      RUN    = 1'b0,
      SQUASH = 1'b1
   } bp_state_t;

endpackage

// File: rtl/bp_entry_fifo.sv
// rtl/bp_entry_fifo.sv - circular buffer of predicted branches with a bulk clear
module bp_entry_fifo
   import bp_pkg::*;
#(
   parameter int  DEPTH = DEF_DEPTH,
   parameter type T     = bp_entry_t
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   wr_en,
   input  T                       wr_data,
   input  logic                   rd_en,
   output T                       rd_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   T              mem [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic          do_wr;
   logic          do_rd;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_wr   = wr_en && !full && !clear;
   assign do_rd   = rd_en && !empty && !clear;
   assign rd_data = mem[head];

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[tail] <= wr_data;
      end
   end

   // clear discards everything queued by snapping head onto tail
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (clear) begin
         head  <= tail;
         count <= '0;
      end else begin
         if (do_rd) begin
            head <= head + PW'(1);
         end
         if (do_wr) begin
            tail <= tail + PW'(1);
         end
         count <= count + CW'(do_wr) - CW'(do_rd);
      end
   end

endmodule

// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - in-order branch retirement feeding predictor training updates
module branch_resolve_queue
   import bp_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic                   CLOCK,
   input  logic                   INIT,
   input  logic                   PUSH_VALID,
   output logic                   PUSH_READY,
   input  logic [ADDR_W-1:0]      PUSH_ADDR,
   input  logic                   PUSH_PRED,
   input  logic                   RES_VALID,
   input  logic                   RES_OUTCOME,
   output logic                   UPD_VALID,
   output logic [ADDR_W-1:0]      UPD_ADDR,
   output logic                   UPD_OUTCOME,
   output logic                   MISPREDICT,
   output logic                   FLUSH,
   output logic [$clog2(DEPTH):0] COUNT,
   output logic [15:0]            MISSES,
   output logic                   RES_ERR
);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              pred;
   } entry_t;

   bp_state_t state;
   bp_state_t next_state;
   entry_t    push_entry;
   entry_t    head_entry;
   logic      fifo_full;
   logic      fifo_empty;
   logic      push_ok;
   logic      push_fire;
   logic      res_fire;
   logic      miss_now;

   assign push_entry = '{addr: PUSH_ADDR, pred: PUSH_PRED};

   bp_entry_fifo #(
      .DEPTH (DEPTH),
      .T     (entry_t)
   ) u_fifo (
      .clk     (CLOCK),
      .rst_n   (INIT),
      .clear   (miss_now),
      .wr_en   (push_fire),
      .wr_data (push_entry),
      .rd_en   (res_fire),
      .rd_data (head_entry),
      .count   (COUNT),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // a push alongside a mispredicting resolve is younger than the bad branch, so it is dropped
   always_comb begin
      next_state = state;
      push_ok    = 1'b0;
      res_fire   = 1'b0;
      miss_now   = 1'b0;
      push_fire  = 1'b0;
      case (state)
         RUN: begin
            push_ok   = !fifo_full;
            res_fire  = RES_VALID && !fifo_empty;
            miss_now  = res_fire && (head_entry.pred != RES_OUTCOME);
            push_fire = PUSH_VALID && push_ok && !miss_now;
            if (miss_now) begin
               next_state = SQUASH;
            end
         end
         SQUASH: begin
            next_state = RUN;
         end
         default: begin
            next_state = RUN;
         end
      endcase
   end

   assign PUSH_READY = push_ok;
   assign FLUSH      = (state == SQUASH);

   always_ff @(posedge CLOCK or negedge INIT) begin
      if (!INIT) begin
         state       <= RUN;
         UPD_VALID   <= 1'b0;
         UPD_ADDR    <= '0;
         UPD_OUTCOME <= 1'b0;
         MISPREDICT  <= 1'b0;
         MISSES      <= '0;
         RES_ERR     <= 1'b0;
      end else begin
         state      <= next_state;
         UPD_VALID  <= res_fire;
         MISPREDICT <= miss_now;
         if (res_fire) begin
            UPD_ADDR    <= head_entry.addr;
            UPD_OUTCOME <= RES_OUTCOME;
         end
         if (miss_now && (MISSES != 16'hFFFF)) begin
            MISSES <= MISSES + 16'd1;
         end
         if (RES_VALID && !res_fire) begin
            RES_ERR <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb/tb_branch_resolve_queue.sv - randomized and directed bench for branch_resolve_queue
module tb_branch_resolve_queue;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 3;
   localparam int CW     = $clog2(DEPTH) + 1;

   logic              CLOCK       = 1'b0;
   logic              INIT        = 1'b0;
   logic              PUSH_VALID  = 1'b0;
   logic              PUSH_READY;
   logic [ADDR_W-1:0] PUSH_ADDR   = '0;
   logic              PUSH_PRED   = 1'b0;
   logic              RES_VALID   = 1'b0;
   logic              RES_OUTCOME = 1'b0;
   logic              UPD_VALID;
   logic [ADDR_W-1:0] UPD_ADDR;
   logic              UPD_OUTCOME;
   logic              MISPREDICT;
   logic              FLUSH;
   logic [CW-1:0]     COUNT;
   logic [15:0]       MISSES;
   logic              RES_ERR;

   typedef struct {
      int addr;
      bit pred;
   } br_t;

   br_t m_q[$];
   bit  m_squash;
   bit  m_err;
   int  m_misses;
   bit  e_uv;
   bit  e_out;
   bit  e_mis;
   int  e_addr;
   int  checks   = 0;
   int  failures = 0;

   branch_resolve_queue #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) dut (
      .CLOCK       (CLOCK),
      .INIT        (INIT),
      .PUSH_VALID  (PUSH_VALID),
      .PUSH_READY  (PUSH_READY),
      .PUSH_ADDR   (PUSH_ADDR),
      .PUSH_PRED   (PUSH_PRED),
      .RES_VALID   (RES_VALID),
      .RES_OUTCOME (RES_OUTCOME),
      .UPD_VALID   (UPD_VALID),
      .UPD_ADDR    (UPD_ADDR),
      .UPD_OUTCOME (UPD_OUTCOME),
      .MISPREDICT  (MISPREDICT),
      .FLUSH       (FLUSH),
      .COUNT       (COUNT),
      .MISSES      (MISSES),
      .RES_ERR     (RES_ERR)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic model_reset();
      m_q.delete();
      m_squash = 1'b0;
      m_err    = 1'b0;
      m_misses = 0;
      e_uv     = 1'b0;
      e_out    = 1'b0;
      e_mis    = 1'b0;
      e_addr   = 0;
   endtask

   // one clock of stimulus; the reference model follows the queue rules directly
   task automatic step(input bit pv, input int pa, input bit pp, input bit rv, input bit ro);
      bit  acc_push;
      br_t e;
      PUSH_VALID  = pv;
      PUSH_ADDR   = ADDR_W'(pa);
      PUSH_PRED   = pp;
      RES_VALID   = rv;
      RES_OUTCOME = ro;
      acc_push = pv && (m_q.size() < DEPTH) && !m_squash;
      @(posedge CLOCK);
      #1;
      e_uv  = 1'b0;
      e_mis = 1'b0;
      if (rv && !m_squash && m_q.size() > 0) begin
         e      = m_q.pop_front();
         e_uv   = 1'b1;
         e_addr = e.addr;
         e_out  = ro;
         e_mis  = (e.pred != ro);
      end else if (rv) begin
         m_err = 1'b1;
      end
      if (e_mis) begin
         m_q.delete();
         acc_push = 1'b0;
         if (m_misses < 65535) m_misses++;
      end
      if (acc_push) m_q.push_back('{pa, pp});
      m_squash   = e_mis;
      PUSH_VALID = 1'b0;
      RES_VALID  = 1'b0;
   endtask

   task automatic test_reset();
      model_reset();
      INIT = 1'b0;
      @(posedge CLOCK);
      #1;
      checks++;
      if ({UPD_VALID, UPD_ADDR, UPD_OUTCOME, MISPREDICT, FLUSH, COUNT, MISSES, RES_ERR} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got=%0h want=0", {UPD_VALID, UPD_ADDR, UPD_OUTCOME, MISPREDICT, FLUSH, COUNT, MISSES, RES_ERR});
      end
      #4 INIT = 1'b1;
      @(posedge CLOCK);
      #1;
      checks++;
      if ({PUSH_READY, COUNT} !== {1'b1, CW'(0)}) begin
         failures++;
         $display("FAIL reset_ready got=%b/%0d want=1/0", PUSH_READY, COUNT);
      end
   endtask

   task automatic test_basic();
      step(1'b1, 3, 1'b1, 1'b0, 1'b0);
      checks++;
      if (COUNT !== CW'(1)) begin failures++; $display("FAIL basic_count got=%0d want=1", COUNT); end
      step(1'b0, 0, 1'b0, 1'b1, 1'b1);
      checks++;
      if ({UPD_VALID, UPD_ADDR, UPD_OUTCOME, MISPREDICT, MISSES} !== {1'b1, 3'd3, 1'b1, 1'b0, 16'd0}) begin
         failures++;
         $display("FAIL basic_update got=%b %0d %b %b %0d want=1 3 1 0 0", UPD_VALID, UPD_ADDR, UPD_OUTCOME, MISPREDICT, MISSES);
      end
   endtask

   task automatic test_mispredict();
      step(1'b1, 1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 2, 1'b1, 1'b0, 1'b0);
      step(1'b1, 5, 1'b1, 1'b0, 1'b0);
      checks++;
      if (COUNT !== CW'(3)) begin failures++; $display("FAIL mis_fill got=%0d want=3", COUNT); end
      step(1'b0, 0, 1'b0, 1'b1, 1'b1);
      checks++;
      if ({UPD_VALID, UPD_ADDR, MISPREDICT, FLUSH, COUNT, MISSES, PUSH_READY} !== {1'b1, 3'd1, 1'b1, 1'b1, CW'(0), 16'd1, 1'b0}) begin
         failures++;
         $display("FAIL mis_flush got=uv%b a%0d m%b f%b c%0d n%0d r%b want=uv1 a1 m1 f1 c0 n1 r0",
                  UPD_VALID, UPD_ADDR, MISPREDICT, FLUSH, COUNT, MISSES, PUSH_READY);
      end
      step(1'b0, 0, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({UPD_VALID, FLUSH, PUSH_READY} !== 3'b001) begin
         failures++;
         $display("FAIL mis_recover got=uv%b f%b r%b want=uv0 f0 r1", UPD_VALID, FLUSH, PUSH_READY);
      end
   endtask

   task automatic test_full_wrap();
      step(1'b1, 7, 1'b1, 1'b0, 1'b0);
      step(1'b0, 0, 1'b0, 1'b1, 1'b1);
      for (int a = 0; a < 4; a++) step(1'b1, a, 1'b1, 1'b0, 1'b0);
      checks++;
      if ({COUNT, PUSH_READY} !== {CW'(4), 1'b0}) begin
         failures++;
         $display("FAIL full_state got=c%0d r%b want=c4 r0", COUNT, PUSH_READY);
      end
      step(1'b1, 7, 1'b0, 1'b0, 1'b0);
      checks++;
      if (COUNT !== CW'(4)) begin failures++; $display("FAIL full_blocked got=%0d want=4", COUNT); end
      for (int a = 0; a < 4; a++) begin
         step(1'b0, 0, 1'b0, 1'b1, 1'b1);
         checks++;
         if ({UPD_VALID, UPD_ADDR, MISPREDICT} !== {1'b1, ADDR_W'(a), 1'b0}) begin
            failures++;
            $display("FAIL wrap_order got=uv%b a%0d m%b want=uv1 a%0d m0", UPD_VALID, UPD_ADDR, MISPREDICT, a);
         end
      end
      checks++;
      if (COUNT !== CW'(0)) begin failures++; $display("FAIL wrap_drain got=%0d want=0", COUNT); end
   endtask

   task automatic test_empty_resolve();
      step(1'b0, 0, 1'b0, 1'b1, 1'b0);
      checks++;
      if ({UPD_VALID, RES_ERR} !== 2'b01) begin
         failures++;
         $display("FAIL empty_resolve got=uv%b e%b want=uv0 e1", UPD_VALID, RES_ERR);
      end
      for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (RES_ERR !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b want=1", RES_ERR); end
   endtask

   task automatic test_same_cycle();
      step(1'b1, 2, 1'b0, 1'b0, 1'b0);
      step(1'b1, 6, 1'b1, 1'b1, 1'b1);
      checks++;
      if ({MISPREDICT, UPD_ADDR, COUNT} !== {1'b1, 3'd2, CW'(0)}) begin
         failures++;
         $display("FAIL same_miss got=m%b a%0d c%0d want=m1 a2 c0", MISPREDICT, UPD_ADDR, COUNT);
      end
      step(1'b0, 0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4, 1'b1, 1'b0, 1'b0);
      step(1'b1, 6, 1'b1, 1'b1, 1'b1);
      checks++;
      if ({MISPREDICT, UPD_ADDR, COUNT} !== {1'b0, 3'd4, CW'(1)}) begin
         failures++;
         $display("FAIL same_hit got=m%b a%0d c%0d want=m0 a4 c1", MISPREDICT, UPD_ADDR, COUNT);
      end
      step(1'b0, 0, 1'b0, 1'b1, 1'b1);
      checks++;
      if ({UPD_VALID, UPD_ADDR, COUNT} !== {1'b1, 3'd6, CW'(0)}) begin
         failures++;
         $display("FAIL same_kept got=uv%b a%0d c%0d want=uv1 a6 c0", UPD_VALID, UPD_ADDR, COUNT);
      end
   endtask

   task automatic test_random();
      logic [CW+20:0] got;
      logic [CW+20:0] want;
      for (int i = 0; i < 400; i++) begin
         step(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)), bit'($urandom_range(0, 7) != 0),
              bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 7) != 0));
         got  = {UPD_VALID, MISPREDICT, FLUSH, RES_ERR, PUSH_READY, COUNT, MISSES};
         want = {e_uv, e_mis, m_squash, m_err, (m_q.size() < DEPTH) && !m_squash, CW'(m_q.size()), 16'(m_misses)};
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL rand_state cycle=%0d got=%h want=%h", i, got, want);
         end
         if (e_uv) begin
            checks++;
            if ({UPD_ADDR, UPD_OUTCOME} !== {ADDR_W'(e_addr), e_out}) begin
               failures++;
               $display("FAIL rand_update cycle=%0d got=a%0d o%b want=a%0d o%b", i, UPD_ADDR, UPD_OUTCOME, e_addr, e_out);
            end
         end
      end
   endtask

   task automatic test_misses_sat();
      step(1'b0, 0, 1'b0, 1'b0, 1'b0);
      while (m_q.size() > 0) step(1'b0, 0, 1'b0, 1'b1, m_q[0].pred);
      for (int k = 0; k < 65537; k++) begin
         step(1'b1, k & 7, 1'b0, 1'b0, 1'b0);
         step(1'b0, 0, 1'b0, 1'b1, 1'b1);
         step(1'b0, 0, 1'b0, 1'b0, 1'b0);
      end
      checks++;
      if (MISSES !== 16'hFFFF) begin failures++; $display("FAIL misses_sat got=%h want=ffff", MISSES); end
      checks++;
      if (MISSES !== 16'(m_misses)) begin failures++; $display("FAIL misses_model got=%h want=%h", MISSES, 16'(m_misses)); end
   endtask

   task automatic test_reset_mid();
      step(1'b1, 5, 1'b0, 1'b0, 1'b0);
      step(1'b1, 2, 1'b1, 1'b0, 1'b0);
      step(1'b0, 0, 1'b0, 1'b1, 1'b1);
      #2 INIT = 1'b0;
      #1;
      checks++;
      if ({UPD_VALID, UPD_ADDR, UPD_OUTCOME, MISPREDICT, FLUSH, COUNT, MISSES, RES_ERR} !== '0) begin
         failures++;
         $display("FAIL async_reset got=%0h want=0", {UPD_VALID, UPD_ADDR, UPD_OUTCOME, MISPREDICT, FLUSH, COUNT, MISSES, RES_ERR});
      end
      #1 INIT = 1'b1;
      model_reset();
      @(posedge CLOCK);
      #1;
      checks++;
      if ({UPD_VALID, PUSH_READY, COUNT, RES_ERR} !== {1'b0, 1'b1, CW'(0), 1'b0}) begin
         failures++;
         $display("FAIL post_reset got=uv%b r%b c%0d e%b want=uv0 r1 c0 e0", UPD_VALID, PUSH_READY, COUNT, RES_ERR);
      end
      step(1'b1, 3, 1'b1, 1'b0, 1'b0);
      step(1'b0, 0, 1'b0, 1'b1, 1'b1);
      checks++;
      if ({UPD_VALID, UPD_ADDR, MISPREDICT, COUNT} !== {1'b1, 3'd3, 1'b0, CW'(0)}) begin
         failures++;
         $display("FAIL post_reset_retire got=uv%b a%0d m%b c%0d want=uv1 a3 m0 c0", UPD_VALID, UPD_ADDR, MISPREDICT, COUNT);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_mispredict();
      test_full_wrap();
      test_empty_resolve();
      test_same_cycle();
      test_random();
      test_misses_sat();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
